// File: rtl/logic_sweeper_pkg.sv
// Shared definitions for the gate-bank self-test sweeper: gate bit positions,
// FSM states and the golden truth-table function.
package logic_pkg;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NOT  = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;
  localparam int NUM_GATES = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Golden outputs of the gate bank for one input pair; NOT observes input a.
  function automatic logic [NUM_GATES-1:0] expected(input logic a, input logic b);
    logic [NUM_GATES-1:0] g;
    g            = '0;
    g[GATE_AND]  = a & b;
    g[GATE_OR]   = a | b;
    g[GATE_NOT]  = ~a;
    g[GATE_NAND] = ~(a & b);
    g[GATE_NOR]  = ~(a | b);
    g[GATE_XOR]  = a ^ b;
    g[GATE_XNOR] = ~(a ^ b);
    return g;
  endfunction

endpackage

// File: rtl/logic_sweeper_if.sv
// Signal bundle between the sweeper and its surroundings: stimulus to the
// gate bank, gate-bank outputs back, and the sweep control/result signals.
interface logic_sweeper_if;

  logic start;
  logic and_in, or_in, not_in, nand_in, nor_in, xor_in, xnor_in;
  logic a, b;
  logic busy, done, pass;
  logic [logic_pkg::NUM_GATES-1:0] fail_mask;
  logic [2:0] fail_count;
  logic [1:0] fail_first;

  // Sweeper side.
  modport slave (
    input  start, and_in, or_in, not_in, nand_in, nor_in, xor_in, xnor_in,
    output a, b, busy, done, pass, fail_mask, fail_count, fail_first
  );

  // Host / gate-bank side.
  modport master (
    output start, and_in, or_in, not_in, nand_in, nor_in, xor_in, xnor_in,
    input  a, b, busy, done, pass, fail_mask, fail_count, fail_first
  );

endinterface

// File: rtl/logic_sweeper.sv
// Built-in self-test for the two-input gate bank: walks {a,b} through 00..11,
// holds each vector SETTLE+1 cycles, then compares all seven outputs to golden.
module logic_sweeper
  import logic_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input logic           clk,
  input logic           rst,
  logic_sweeper_if.slave bus
);

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t               state, state_nxt;
  logic [1:0]           idx;
  logic [3:0]           cnt;
  logic                 a_q, b_q;
  logic                 pass_q;
  logic [NUM_GATES-1:0] mask_q;
  logic [2:0]           count_q;
  logic [1:0]           first_q;
  logic [NUM_GATES-1:0] sampled;
  logic [NUM_GATES-1:0] mism;
  logic                 sample_now;

  assign sampled[GATE_AND]  = bus.and_in;
  assign sampled[GATE_OR]   = bus.or_in;
  assign sampled[GATE_NOT]  = bus.not_in;
  assign sampled[GATE_NAND] = bus.nand_in;
  assign sampled[GATE_NOR]  = bus.nor_in;
  assign sampled[GATE_XOR]  = bus.xor_in;
  assign sampled[GATE_XNOR] = bus.xnor_in;

  assign mism       = sampled ^ expected(a_q, b_q);
  assign sample_now = (state == ST_APPLY) && (cnt == 4'd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_APPLY;
      ST_APPLY: if (sample_now && idx == 2'd3) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= 2'd0;
      cnt     <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= '0;
      count_q <= 3'd0;
      first_q <= 2'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            idx     <= 2'd0;
            cnt     <= SETTLE_CNT;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            pass_q  <= 1'b0;
            mask_q  <= '0;
            count_q <= 3'd0;
            first_q <= 2'd0;
          end
        end
        ST_APPLY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            mask_q <= mask_q | mism;
            if (|mism) begin
              count_q <= count_q + 3'd1;
              if (count_q == 3'd0) first_q <= {a_q, b_q};
            end
            if (idx != 2'd3) begin
              idx        <= idx + 2'd1;
              {a_q, b_q} <= idx + 2'd1;
              cnt        <= SETTLE_CNT;
            end else begin
              // Result must already include the last vector's mismatches.
              a_q    <= 1'b0;
              b_q    <= 1'b0;
              pass_q <= ((mask_q | mism) == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.a          = a_q;
  assign bus.b          = b_q;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_DONE);
  assign bus.pass       = pass_q;
  assign bus.fail_mask  = mask_q;
  assign bus.fail_count = count_q;
  assign bus.fail_first = first_q;

endmodule

// File: tb/tb_logic_sweeper.sv
// Directed bench: a behavioural gate bank with injectable faults drives a
// SETTLE=1 sweeper; two more sweepers see a 3-stage delayed bank.
module tb_logic_sweeper;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fault = 0;

  always #5 clk = ~clk;

  logic_sweeper_if bus1 ();
  logic_sweeper_if bus3 ();
  logic_sweeper_if bus2 ();

  logic_sweeper #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  logic_sweeper #(.SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  logic_sweeper #(.SETTLE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Gate bank model, order {xnor,xor,nor,nand,not,or,and}.
  function automatic logic [6:0] bank(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  endfunction

  logic [6:0] g1;
  always_comb begin
    g1 = bank(bus1.a, bus1.b);
    if (fault == 1) g1[5] = 1'b0;
    if (fault == 2) begin
      g1[0] = bus1.a | bus1.b;
      g1[1] = bus1.a & bus1.b;
    end
  end
  assign {bus1.xnor_in, bus1.xor_in, bus1.nor_in, bus1.nand_in,
          bus1.not_in, bus1.or_in, bus1.and_in} = g1;

  logic [6:0] p3 [3];
  logic [6:0] p2 [3];
  always @(posedge clk) begin
    p3[0] <= bank(bus3.a, bus3.b);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    p2[0] <= bank(bus2.a, bus2.b);
    p2[1] <= p2[0];
    p2[2] <= p2[1];
  end
  assign {bus3.xnor_in, bus3.xor_in, bus3.nor_in, bus3.nand_in,
          bus3.not_in, bus3.or_in, bus3.and_in} = p3[2];
  assign {bus2.xnor_in, bus2.xor_in, bus2.nor_in, bus2.nand_in,
          bus2.not_in, bus2.or_in, bus2.and_in} = p2[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_ab"},    {bus1.a, bus1.b}, 2'b00);
    check({tag, "_busy"},  bus1.busy, 1'b0);
    check({tag, "_done"},  bus1.done, 1'b0);
    check({tag, "_pass"},  bus1.pass, 1'b0);
    check({tag, "_mask"},  bus1.fail_mask, 7'd0);
    check({tag, "_count"}, bus1.fail_count, 3'd0);
    check({tag, "_first"}, bus1.fail_first, 2'd0);
  endtask

  // Leaves the caller at the negedge right after E0.
  task automatic pulse_start1();
    @(negedge clk); bus1.start = 1'b1;
    @(negedge clk); bus1.start = 1'b0;
  endtask

  // Full SETTLE=1 sweep on dut1 with cycle-exact sequence and result checks.
  task automatic sweep(input string tag, input bit poke, input bit exp_pass,
                       input logic [6:0] exp_mask, input logic [2:0] exp_cnt,
                       input logic [1:0] exp_first);
    pulse_start1();
    for (int k = 0; k < 8; k++) begin
      check({tag, "_ab"},   {bus1.a, bus1.b}, 32'(k / 2));
      check({tag, "_busy"}, bus1.busy, 1'b1);
      check({tag, "_done"}, bus1.done, 1'b0);
      if (poke) bus1.start = (k == 3);
      @(negedge clk);
    end
    bus1.start = 1'b0;
    check({tag, "_done8"}, bus1.done, 1'b1);
    check({tag, "_busy8"}, bus1.busy, 1'b1);
    check({tag, "_ab8"},   {bus1.a, bus1.b}, 2'b00);
    check({tag, "_pass"},  bus1.pass, exp_pass);
    check({tag, "_mask"},  bus1.fail_mask, exp_mask);
    check({tag, "_count"}, bus1.fail_count, exp_cnt);
    check({tag, "_first"}, bus1.fail_first, exp_first);
    @(negedge clk);
    check({tag, "_done9"}, bus1.done, 1'b0);
    check({tag, "_busy9"}, bus1.busy, 1'b0);
    check({tag, "_hold"},  bus1.pass, exp_pass);
  endtask

  initial begin
    bit   seen3, seen2;
    int   cyc3, cyc2;
    logic pass3, pass2;
    logic [1:0] first2;

    rst = 1'b1;
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    bus2.start = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_reset("rst");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    sweep("healthy", 1'b0, 1'b1, 7'b0000000, 3'd0, 2'b00);
    fault = 1;
    sweep("xor_sa0", 1'b0, 1'b0, 7'b0100000, 3'd2, 2'b01);
    fault = 2;
    sweep("and_or_swap", 1'b0, 1'b0, 7'b0000011, 3'd2, 2'b01);
    fault = 0;
    sweep("midstart", 1'b1, 1'b1, 7'b0000000, 3'd0, 2'b00);

    // Abort with a faulty bank so a surviving partial result would show up.
    fault = 1;
    pulse_start1();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_reset("midrst");
    rst = 1'b0;
    fault = 0;
    @(negedge clk);
    sweep("after_rst", 1'b0, 1'b1, 7'b0000000, 3'd0, 2'b00);

    // Delayed bank: SETTLE=3 tolerates 3 stages, SETTLE=2 does not.
    repeat (4) @(negedge clk);
    bus3.start = 1'b1;
    bus2.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    bus2.start = 1'b0;
    seen3 = 1'b0; seen2 = 1'b0; cyc3 = 0; cyc2 = 0;
    pass3 = 1'b0; pass2 = 1'b1; first2 = 2'b00;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus3.done && !seen3) begin
        seen3 = 1'b1; cyc3 = i; pass3 = bus3.pass;
      end
      if (bus2.done && !seen2) begin
        seen2 = 1'b1; cyc2 = i; pass2 = bus2.pass; first2 = bus2.fail_first;
      end
    end
    check("s3_seen",  seen3, 1'b1);
    check("s3_cycle", cyc3, 32'd16);
    check("s3_pass",  pass3, 1'b1);
    check("s2_seen",  seen2, 1'b1);
    check("s2_cycle", cyc2, 32'd12);
    check("s2_pass",  pass2, 1'b0);
    check("s2_first", first2, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
